fifo_drain_fsm: RTL and testbench

Read-side controller for the 8-entry byte FIFO filled by the write-side hysteresis FSM. It waits until the FIFO holds at least START_LEVEL words, then drains it to empty at up to one word per cycle. Each word passes through a 3-entry output buffer onto a valid/ready stream, and every word is checked against the expected fill pattern.

---
 rtl/fifo_drain_fsm.sv | 90 +++++++++
 tb/tb_fifo_drain_fsm.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_fsm.sv
// Read-side FIFO controller: waits for START_LEVEL words, drains to empty through a
// 3-entry valid/ready output buffer, and counts words that differ from EXPECTED.
module fifo_drain_fsm #(
    parameter int unsigned START_LEVEL = 3,
    parameter logic [7:0]  EXPECTED    = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rd_en,
    input  logic [7:0]  fifo_data,
    input  logic [3:0]  fifo_words,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  err_count,
    output logic [15:0] word_count
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e     state_q;
    logic [1:0] occ_q;
    logic [1:0] occ_d;
    logic [1:0] wr_idx;
    logic       inflight_q;
    logic [7:0] buf_q [3];
    logic       push;
    logic       pop;
    logic       words_nz;
    logic       start;

    assign words_nz = (fifo_words != 4'd0);
    assign start    = ({28'd0, fifo_words} >= START_LEVEL);

    // Reads are budgeted against buffer space only; the same-cycle pop is deliberately ignored
    // so out_ready never reaches rd_en combinationally.
    assign rd_en = (state_q == StDrain) && words_nz &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);

    assign push     = inflight_q;
    assign pop      = out_valid && out_ready;
    assign wr_idx   = occ_q - {1'b0, pop};
    assign out_data = buf_q[0];

    always_comb begin
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            out_valid  <= 1'b0;
            err_count  <= 8'd0;
            word_count <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= 8'd0;
            end
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_q <= StDrain;
                StDrain: if (!words_nz) state_q <= StIdle;
            endcase

            inflight_q <= rd_en;
            occ_q      <= occ_d;
            out_valid  <= (occ_d != 2'd0);

            // Shift-register buffer: head at index 0; a push lands behind the post-pop tail.
            if (pop) begin
                buf_q[0] <= buf_q[1];
                buf_q[1] <= buf_q[2];
            end
            if (push) begin
                buf_q[wr_idx] <= fifo_data;
                word_count    <= word_count + 16'd1;
                if ((fifo_data != EXPECTED) && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Bench for fifo_drain_fsm: FIFO model with 1-cycle read latency, scoreboard of words read,
// and a monitor comparing every accepted output word in order.
module tb_fifo_drain_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en;
    logic [7:0]  fifo_data;
    logic [3:0]  fifo_words;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fifo_drain_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .fifo_data  (fifo_data),
        .fifo_words (fifo_words),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_count  (err_count),
        .word_count (word_count)
    );

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         rd_pulses = 0;
    logic       last_rd = 1'b0;
    logic       last_ov = 1'b0;
    logic       pending = 1'b0;
    logic       rd_log [2048];
    logic       ov_log [2048];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One clock cycle, entered and left at a negedge. Also models the FIFO: a word is removed
    // at the edge that samples rd_en=1 and presented on fifo_data in the following cycle.
    task automatic cycle();
        fifo_words = (fifo_q.size() > 8) ? 4'd8 : 4'(fifo_q.size());
        #1;
        pending = (rd_en === 1'b1);
        last_rd = pending;
        last_ov = (out_valid === 1'b1);
        if (cyc < 2048) begin
            rd_log[cyc] = last_rd;
            ov_log[cyc] = last_ov;
        end
        if (pending) rd_pulses++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
        if (!rst_n) exp_q.delete();
        if (pending) begin
            fifo_data = fifo_q.pop_front();
            if (rst_n) exp_q.push_back(fifo_data);
        end
    endtask

    task automatic run_until_idle(input int max_cycles, input string name);
        int n = 0;
        while (n < max_cycles &&
               !(fifo_q.size() == 0 && exp_q.size() == 0 && !last_ov && !last_rd)) begin
            cycle();
            n++;
        end
        check({name, "_drain_done"}, (n < max_cycles) ? 1 : 0, 1);
    endtask

    // Monitor: every accepted word must be the next word the FIFO handed over.
    always @(negedge clk) begin
        #2;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got word %02h, expected no word", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_word", int'(out_data), int'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        int s;
        int f;
        int l;
        int np;
        int fo;
        int lo;
        int no;
        int n;
        int remaining;

        rst_n      = 1'b0;
        out_ready  = 1'b0;
        fifo_data  = 8'd0;
        fifo_words = 4'd0;
        @(negedge clk);

        // Reset with a full FIFO
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
        cycle();
        cycle();
        check("rst_rd_en", int'(last_rd), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_word_count", int'(word_count), 0);
        check("rst_err_count", int'(err_count), 0);

        // Backpressure: only 3 reads may be issued
        rst_n     = 1'b1;
        rd_pulses = 0;
        repeat (10) cycle();
        check("bp_rd_pulses", rd_pulses, 3);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_word_count", int'(word_count), 3);
        check("bp_fifo_left", fifo_q.size(), 5);
        out_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (!last_ov) gaps++;
        end
        check("bp_no_gaps", gaps, 0);
        run_until_idle(40, "bp");
        check("bp_word_count_end", int'(word_count), 8);
        check("bp_err_count_end", int'(err_count), 8);

        // Threshold and error counting
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("rst2_word_count", int'(word_count), 0);
        check("rst2_err_count", int'(err_count), 0);
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'h55);
        rd_pulses = 0;
        repeat (10) cycle();
        check("thr_below_rd", rd_pulses, 0);
        fifo_q.push_back(8'hAA);
        cycle();
        check("thr_edge_rd", int'(last_rd), 0);
        cycle();
        check("thr_next_rd", int'(last_rd), 1);
        fifo_q.push_back(8'h00);
        run_until_idle(40, "err");
        check("err_word_count", int'(word_count), 4);
        check("err_err_count", int'(err_count), 2);

        // Full-rate burst of 5 matching words
        s = cyc;
        repeat (5) fifo_q.push_back(8'hAA);
        run_until_idle(40, "burst");
        f = -1; l = -1; np = 0; fo = -1; lo = -1; no = 0;
        for (int i = s; i < cyc && i < 2048; i++) begin
            if (rd_log[i]) begin
                if (f < 0) f = i;
                l = i;
                np++;
            end
            if (ov_log[i]) begin
                if (fo < 0) fo = i;
                lo = i;
                no++;
            end
        end
        check("burst_first_rd", f - s, 1);
        check("burst_rd_pulses", np, 5);
        check("burst_rd_span", l - f, 4);
        check("burst_ov_delay", fo - f, 2);
        check("burst_ov_cycles", no, 5);
        check("burst_ov_span", lo - fo, 4);
        check("burst_word_count", int'(word_count), 9);
        check("burst_err_count", int'(err_count), 2);

        // Back in idle: two words must not start a drain
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h11);
        rd_pulses = 0;
        repeat (5) cycle();
        check("idle_after_burst_rd", rd_pulses, 0);

        // 300 mismatching words in total: error counter saturates
        remaining = 298;
        n = 0;
        while (remaining > 0 && n < 3000) begin
            if (fifo_q.size() < 8) begin
                fifo_q.push_back(8'h11);
                remaining--;
            end
            cycle();
            n++;
        end
        check("sat_feed_done", (n < 3000) ? 1 : 0, 1);
        run_until_idle(60, "sat");
        check("sat_word_count", int'(word_count), 309);
        check("sat_err_count", int'(err_count), 255);

        // Reset while occ=2 and one word in flight
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'hA0 + 8'(i));
        rd_pulses = 0;
        n = 0;
        while (rd_pulses < 3 && n < 20) begin
            cycle();
            n++;
        end
        check("mid_reads_issued", rd_pulses, 3);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_out_valid", int'(out_valid), 0);
        check("mid_word_count", int'(word_count), 0);
        check("mid_err_count", int'(err_count), 0);
        out_ready = 1'b1;
        run_until_idle(40, "mid");
        check("mid_word_count_end", int'(word_count), 5);
        check("mid_err_count_end", int'(err_count), 5);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
